// File: rtl/io_timer_multi.sv
// io_timer_multi: prescaled free-running counter with NCH compare channels on the dma_io bus
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   dma_io_we/wadr/wdata        register write port, word address [15:2]
//   dma_io_radr/radr_en         register read port, data returned one cycle later
//   dma_io_rdata_in/rdata       read-data daisy chain, passes through when not hit
//   csr_mtie                    global timer interrupt enable
//   irq_ch                      per-channel interrupt (pending & IE)
//   irq                         combined interrupt gated by csr_mtie
// Optional feature: define IO_TMR_HI_LATCH_EN to latch CNT_HI when CNT_LO is read.
module io_timer_multi #(
    parameter logic [15:0] BASE_ADR = 16'hC400,
    parameter int          NCH      = 2,
    parameter int          CNT_W    = 48,
    parameter int          PRE_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dma_io_we,
    input  logic [13:0]      dma_io_wadr,
    input  logic [31:0]      dma_io_wdata,
    input  logic [13:0]      dma_io_radr,
    input  logic             dma_io_radr_en,
    input  logic [31:0]      dma_io_rdata_in,
    output logic [31:0]      dma_io_rdata,
    input  logic             csr_mtie,
    output logic [NCH-1:0]   irq_ch,
    output logic             irq
);
    localparam logic [13:0] BASE_W = BASE_ADR[15:2];

    // Block window is 64 words; offsets wrap below the base so they fall outside
    logic [13:0] woff, roff;
    logic wr, rhit, wr_ctrl, clr, tick, ticked;
    logic en_q, en_d;
    logic [PRE_W-1:0] pre_q, pre_d, psc_q, psc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_ld;
    logic [NCH-1:0] pend_q, pend_d, ie_q, ie_d, prd_q, prd_d, arm_q, arm_d, match;
    logic [31:0] cmp_q [NCH];
    logic [31:0] cmp_d [NCH];
    logic [31:0] per_q [NCH];
    logic [31:0] per_d [NCH];
    logic [31:0] rd_q, rd_d, rd_ch, cnt_hi, hi_rd;
    logic hit_q;

    assign woff = dma_io_wadr - BASE_W;
    assign roff = dma_io_radr - BASE_W;
    assign wr = dma_io_we && woff < 14'd64;
    assign rhit = dma_io_radr_en && roff < 14'd64;
    assign cnt_hi = 32'(64'(cnt_q) >> 32);

    always_comb begin
        wr_ctrl = wr && woff == 14'd0;
        clr = wr_ctrl && dma_io_wdata[1];
        tick = en_q && psc_q == pre_q;
        ticked = tick && !clr;
        en_d = wr_ctrl ? dma_io_wdata[0] : en_q;
        pre_d = wr_ctrl ? dma_io_wdata[PRE_W+7:8] : pre_q;
        psc_d = (wr_ctrl || tick) ? '0 : en_q ? psc_q + PRE_W'(1) : psc_q;
        cnt_ld = cnt_q;
        cnt_ld[31:0] = dma_io_wdata;
        cnt_d = clr ? '0 : (wr && woff == 14'd1) ? cnt_ld : tick ? cnt_q + CNT_W'(1) : cnt_q;
        match = '0;
        for (int n = 0; n < NCH; n++) begin
            // compare against the value being loaded on this edge
            match[n] = ticked && arm_q[n] && cnt_d[31:0] == cmp_q[n];
            cmp_d[n] = (wr && woff == 14'(4 + 4 * n)) ? dma_io_wdata :
                       (match[n] && prd_q[n]) ? cmp_q[n] + per_q[n] : cmp_q[n];
            per_d[n] = (wr && woff == 14'(5 + 4 * n)) ? dma_io_wdata : per_q[n];
            ie_d[n] = (wr && woff == 14'(6 + 4 * n)) ? dma_io_wdata[0] : ie_q[n];
            prd_d[n] = (wr && woff == 14'(6 + 4 * n)) ? dma_io_wdata[1] : prd_q[n];
            arm_d[n] = (wr && woff == 14'(6 + 4 * n)) ? dma_io_wdata[2] :
                       arm_q[n] && !(match[n] && !prd_q[n]);
        end
        // a match set overrides a same-cycle W1C of that bit
        pend_d = (pend_q & ~((wr && woff == 14'd3) ? dma_io_wdata[NCH-1:0] : '0)) | match;
    end

    always_comb begin
        rd_ch = '0;
        for (int n = 0; n < NCH; n++)
            if (roff[13:2] == 12'(n + 1))
                rd_ch = roff[1:0] == 2'd0 ? cmp_q[n] :
                        roff[1:0] == 2'd1 ? per_q[n] :
                        roff[1:0] == 2'd2 ? {29'd0, arm_q[n], prd_q[n], ie_q[n]} : '0;
        rd_d = !rhit ? '0 :
               roff == 14'd0 ? 32'({pre_q, 7'd0, en_q}) :
               roff == 14'd1 ? cnt_q[31:0] :
               roff == 14'd2 ? hi_rd :
               roff == 14'd3 ? 32'(pend_q) : rd_ch;
    end

`ifdef IO_TMR_HI_LATCH_EN
    logic [31:0] sh_q, sh_d;

    always_comb sh_d = (rhit && roff == 14'd1) ? cnt_hi : sh_q;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            sh_q <= '0;
        else
            sh_q <= sh_d;

    assign hi_rd = sh_q;
`else
    assign hi_rd = cnt_hi;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= 1'b0;
            pre_q <= '0;
            psc_q <= '0;
            cnt_q <= '0;
            pend_q <= '0;
            ie_q <= '0;
            prd_q <= '0;
            arm_q <= '0;
            cmp_q <= '{default: '0};
            per_q <= '{default: '0};
            rd_q <= '0;
            hit_q <= 1'b0;
        end else begin
            en_q <= en_d;
            pre_q <= pre_d;
            psc_q <= psc_d;
            cnt_q <= cnt_d;
            pend_q <= pend_d;
            ie_q <= ie_d;
            prd_q <= prd_d;
            arm_q <= arm_d;
            cmp_q <= cmp_d;
            per_q <= per_d;
            rd_q <= rd_d;
            hit_q <= rhit;
        end
    end

    assign irq_ch = pend_q & ie_q;
    assign irq = (|irq_ch) & csr_mtie;
    assign dma_io_rdata = hit_q ? rd_q : dma_io_rdata_in;
endmodule

// File: doc/io_timer_multi.md
# io_timer_multi

Parametrised multi-channel timer peripheral on the shared `dma_io` register bus, successor to `io_frc`. It contains one free-running counter of configurable width with a prescaler, and `NCH` compare channels. Each channel supports one-shot or periodic auto-reload mode and has its own pending flag. It joins the `dma_io_rdata_in`/`dma_io_rdata` daisy chain and drives per-channel and combined interrupt lines toward `cpu_top`.

## Interface
- `BASE_ADR`, 16'hC400: byte base address; bits [15:2] are compared against the bus word address.
- `NCH`, 2: number of compare channels, legal range 1..4.
- `CNT_W`, 48: counter width, legal range 32..64.
- `PRE_W`, 8: prescaler field width.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `dma_io_we`  in  1: register write strobe.
- `dma_io_wadr`  in  14 [15:2]: write word address.
- `dma_io_wdata`  in  32: write data.
- `dma_io_radr`  in  14 [15:2]: read word address.
- `dma_io_radr_en`  in  1: read strobe.
- `dma_io_rdata_in`  in  32: read data from the upstream chain member.
- `dma_io_rdata`  out  32: read data to the downstream chain member.
- `csr_mtie`  in  1: global timer interrupt enable from the CPU CSR.
- `irq_ch`  out  NCH: per-channel interrupt, `pending[n] & ie[n]`.
- `irq`  out  1: `|irq_ch & csr_mtie`.

## Operation
Register map, as byte offsets from `BASE_ADR`:
- 0x00 CTRL
  - [0] EN: counter enable.
  - [1] CLR: write-1 self-clearing; reads 0.
  - [PRE_W+7:8] PRE: prescaler value.
- 0x04 CNT_LO: count[31:0]. Writable; the write loads the low word.
- 0x08 CNT_HI: count[CNT_W-1:32], zero-extended. Read-only; reads 0 when CNT_W = 32.
- 0x0C STATUS: pending[NCH-1:0]. Writing 1 to a bit clears it (W1C).
- 0x10+0x10·n CMP_n: 32-bit compare value.
- 0x14+0x10·n PER_n: 32-bit reload period.
- 0x18+0x10·n CHCTL_n
  - [0] IE: interrupt enable.
  - [1] PERIODIC: auto-reload mode.
  - [2] ARM: channel armed.
- All other offsets, including addresses at or above 0x10+0x10·NCH, read 0 when addressed and ignore writes.

Prescaler and counter:
- A tick occurs when EN=1 and the prescaler counter equals PRE. The prescaler then returns to 0; otherwise it increments.
- Each tick increments `count`. It wraps from 2^CNT_W−1 to 0.
- CLR, or any write to CTRL, zeroes the prescaler counter. CLR also zeroes `count`. CLR takes priority over a tick in the same cycle.

Compare, evaluated only on a tick:
- Channel n matches when ARM_n=1 and `count_next[31:0] == CMP_n`.
- On a match, `pending[n]` is set on the same edge that loads `count_next`.
- PERIODIC=1: `CMP_n <= CMP_n + PER_n`, mod 2^32; ARM stays set.
- PERIODIC=0: ARM_n clears (one-shot).

Collision rules:
- A match-set and a STATUS W1C of the same bit in the same cycle: set wins.
- A bus write to CMP_n or CHCTL_n in the same cycle as a match reload/disarm: the bus write wins. The pending bit is still set.

Read path:
- A hit is `dma_io_radr_en` with `dma_io_radr` inside the block window.
- The read data is registered, and a one-cycle `hit_q` flag is registered.
- `dma_io_rdata = hit_q ? rd_q : dma_io_rdata_in`.

## Timing
- Reset values:
  - All registers 0; counter stopped.
  - `irq_ch = 0`, `irq = 0`.
  - `hit_q = 0`, so `dma_io_rdata` passes `dma_io_rdata_in`.
- Writes are sampled at the clock edge where `dma_io_we` is high and are visible in the next cycle.
- Read latency: address presented in cycle N, data on `dma_io_rdata` in cycle N+1 only.
- With PRE = p, the count advances once every p+1 cycles once EN is set. The first tick comes p+1 cycles after the CTRL write.
- `irq_ch[n]` is combinational from the registers. It rises in the same cycle the matching count value appears.
- Asserting `rst` mid-operation clears all state immediately. No partial bus transaction survives.

## Configuration
- `IO_TMR_HI_LATCH_EN`
  - Defined: a read hit on CNT_LO also captures count[CNT_W-1:32] into a shadow register. CNT_HI then returns the shadow, giving an atomic 64-bit read sequence (LO then HI). The shadow resets to 0.
  - Undefined: CNT_HI returns the live upper bits, and no shadow register exists.

## Test plan
1. Reset: write CTRL=0x0000_0001 (PRE=0). `count` then reads 1, 2, 3… on consecutive cycles. A read of an unmapped address returns `dma_io_rdata_in` (e.g. 0xA5A5_A5A5) passed through.
2. PRE=3, CMP_0=10, CHCTL_0=0x5 (one-shot):
   - `irq_ch[0]` rises when `count` becomes 10, 40 cycles after EN.
   - ARM_0 reads 0 afterwards.
   - W1C STATUS=0x1 drops `irq_ch[0]` the next cycle.
3. Periodic channel 1, CMP_1=5, PER_1=5, PRE=0: pending sets at counts 5, 10 and 15. CMP_1 reads 20 afterwards.
4. Wrap: load CNT_LO=0xFFFF_FFFF with CNT_W=32, CMP_0=0, armed. The next tick wraps `count` to 0 and sets `pending[0]`.
5. Collision: a W1C of `pending[0]` in the same cycle as a channel-0 match leaves `pending[0]=1`. CLR together with EN=1 gives `count=0` on the following cycle.
6. With `IO_TMR_HI_LATCH_EN` and CNT_W=48: read CNT_LO, let the upper word roll over, then read CNT_HI. CNT_HI returns the pre-rollover value. `irq` is 0 while `csr_mtie=0` even with `irq_ch` set.
